// File: rtl/frame_queue_reader_pkg.sv
// Shared frame-queue definitions: marker words, FSM states, word classes and the
// beat payload used by the reader, its skid buffer and any pattern generator.
package frame_queue_reader_pkg;

  localparam logic [16:0] MK_FRAME_START = 17'h10000;
  localparam logic [16:0] MK_ROW_START   = 17'h10001;
  localparam logic [16:0] MK_FRAME_END   = 17'h1FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ROW,
    ST_IN_ROW
  } state_e;

  typedef enum logic [2:0] {
    W_PIXEL,
    W_FRAME_START,
    W_ROW_START,
    W_FRAME_END,
    W_UNKNOWN
  } word_e;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        sol;
  } beat_t;

  function automatic word_e classify(input logic [16:0] w);
    if (!w[16])                   return W_PIXEL;
    else if (w == MK_FRAME_START) return W_FRAME_START;
    else if (w == MK_ROW_START)   return W_ROW_START;
    else if (w == MK_FRAME_END)   return W_FRAME_END;
    else                          return W_UNKNOWN;
  endfunction

endpackage

// File: rtl/frame_queue_reader_if.sv
// Source FIFO read port plus the outgoing pixel stream. master = reader side,
// slave = the environment (FIFO owner and pixel sink).
interface frame_queue_reader_if;
  logic        queue_empty;
  logic [16:0] queue_data;
  logic        queue_rd_en;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel_sof;
  logic        pixel_sol;

  modport master (
    input  queue_empty, queue_data, pixel_ready,
    output queue_rd_en, pixel_data, pixel_valid, pixel_sof, pixel_sol
  );

  modport slave (
    output queue_empty, queue_data, pixel_ready,
    input  queue_rd_en, pixel_data, pixel_valid, pixel_sof, pixel_sol
  );
endinterface

// File: rtl/pixel_skid_buffer.sv
// Two-entry in-order beat buffer; slot0 is always the presented head, so the
// head stays stable until it is popped.
module pixel_skid_buffer
  import frame_queue_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_valid,
  input  beat_t      push_beat,
  input  logic       pop_ready,
  output logic       out_valid,
  output beat_t      out_beat,
  output logic [1:0] count
);

  beat_t      slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0] count_q, count_d, count_after_pop;
  logic       pop;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;
    pop             = (count_q != 2'd0) && pop_ready;
    count_after_pop = count_q - {1'b0, pop};
    if (pop) slot0_d = slot1_q;
    if (push_valid) begin
      if (count_after_pop == 2'd0) slot0_d = push_beat;
      else                         slot1_d = push_beat;
    end
    count_d = count_after_pop + {1'b0, push_valid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage slots are reset too, because pixel_data must read zero in reset.
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking so each flop samples the pre-edge values of its peers.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_beat  = slot0_q;
  assign count     = count_q;

endmodule

// File: rtl/frame_queue_reader.sv
// Decodes a marker-delimited pixel stream from a FIFO into sof/sol-tagged beats.
// Define FRAME_GEOMETRY_CHECK_EN to flag rows/frames whose size differs from the parameters.
module frame_queue_reader
  import frame_queue_reader_pkg::*;
#(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic                        clk,
  input  logic                        reset_n,
  frame_queue_reader_if.master        fq,
  output logic                        frame_done,
  output logic                        err_pulse,
  output logic [15:0]                 err_count
);

`ifdef FRAME_GEOMETRY_CHECK_EN
  localparam bit GEOM_EN = 1'b1;
`else
  localparam bit GEOM_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        inflight_q, inflight_d;
  logic        sof_arm_q, sof_arm_d, sol_arm_q, sol_arm_d;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic        frame_done_q, frame_done_d, err_pulse_q, err_pulse_d;
  logic [15:0] err_count_q, err_count_d;

  word_e       word_cls;
  logic        push_valid, beat_xfer, err_now, done_now;
  logic        row_len_bad, rows_bad_closing, rows_bad_idle;
  beat_t       push_beat, out_beat;
  logic [1:0]  buf_count, occ_after_pop;

  pixel_skid_buffer u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (push_valid),
    .push_beat  (push_beat),
    .pop_ready  (fq.pixel_ready),
    .out_valid  (fq.pixel_valid),
    .out_beat   (out_beat),
    .count      (buf_count)
  );

  assign fq.pixel_data = out_beat.data;
  assign fq.pixel_sof  = out_beat.sof;
  assign fq.pixel_sol  = out_beat.sol;

  // Occupancy is counted after this cycle's transfer so a full-rate stream never stalls.
  assign beat_xfer      = fq.pixel_valid && fq.pixel_ready;
  assign occ_after_pop  = buf_count - {1'b0, beat_xfer};
  assign fq.queue_rd_en = reset_n && !fq.queue_empty &&
                          (({1'b0, occ_after_pop} + {2'b0, inflight_q}) < 3'd2);

  assign word_cls         = classify(fq.queue_data);
  assign row_len_bad      = GEOM_EN && (int'(col_q) != FRAME_WIDTH);
  assign rows_bad_closing = GEOM_EN && ((int'(row_q) + 1) != FRAME_HEIGHT);
  assign rows_bad_idle    = GEOM_EN && (int'(row_q) != FRAME_HEIGHT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      inflight_q   <= 1'b0;
      sof_arm_q    <= 1'b0;
      sol_arm_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      sof_arm_q    <= sof_arm_d;
      sol_arm_q    <= sol_arm_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next-state: FSM transitions and the geometry counters.
  always_comb begin
    state_d    = state_q;
    inflight_d = fq.queue_rd_en;
    sof_arm_d  = sof_arm_q;
    sol_arm_d  = sol_arm_q;
    col_d      = col_q;
    row_d      = row_q;
    if (inflight_q && word_cls != W_UNKNOWN) begin
      if (word_cls == W_FRAME_START) begin
        state_d   = ST_WAIT_ROW;
        col_d     = '0;
        row_d     = '0;
        sof_arm_d = 1'b1;
        sol_arm_d = 1'b0;
      end else begin
        case (state_q)
          ST_WAIT_ROW: begin
            if (word_cls == W_ROW_START) begin
              state_d   = ST_IN_ROW;
              col_d     = '0;
              sol_arm_d = 1'b1;
            end else if (word_cls == W_FRAME_END) begin
              state_d = ST_IDLE;
            end
          end
          ST_IN_ROW: begin
            if (word_cls == W_PIXEL) begin
              if (col_q != 11'h7FF) col_d = col_q + 11'd1;
              sof_arm_d = 1'b0;
              sol_arm_d = 1'b0;
            end else begin
              if (row_q != 11'h7FF) row_d = row_q + 11'd1;
              col_d = '0;
              if (word_cls == W_ROW_START) sol_arm_d = 1'b1;
              else                         state_d   = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs: beat push, frame_done and error detection for the decoded word.
  always_comb begin
    push_valid = 1'b0;
    push_beat  = beat_t'{data: fq.queue_data[15:0], sof: sof_arm_q, sol: sol_arm_q};
    err_now    = 1'b0;
    done_now   = 1'b0;
    if (inflight_q) begin
      if (word_cls == W_UNKNOWN) begin
        err_now = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: err_now = (word_cls != W_FRAME_START);
          ST_WAIT_ROW: begin
            err_now  = (word_cls == W_PIXEL) || (word_cls == W_FRAME_START) ||
                       ((word_cls == W_FRAME_END) && rows_bad_idle);
            done_now = (word_cls == W_FRAME_END);
          end
          ST_IN_ROW: begin
            push_valid = (word_cls == W_PIXEL);
            done_now   = (word_cls == W_FRAME_END);
            err_now    = (word_cls == W_FRAME_START) ||
                         ((word_cls == W_ROW_START) && row_len_bad) ||
                         ((word_cls == W_FRAME_END) && (row_len_bad || rows_bad_closing));
          end
          default: ;
        endcase
      end
    end
    frame_done_d = done_now;
    err_pulse_d  = err_now;
    err_count_d  = (err_now && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  end

  assign frame_done = frame_done_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_frame_queue_reader.sv
// Scoreboard bench for frame_queue_reader with a 4x2 frame geometry; a FIFO model
// feeds the reader and a monitor compares every transferred beat against the queue.
module tb_frame_queue_reader;
  import frame_queue_reader_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_done, err_pulse;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  frame_queue_reader_if fq();

  frame_queue_reader #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fq         (fq),
    .frame_done (frame_done),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  int          checks = 0, errors = 0;
  logic [16:0] fifo[$];
  logic [17:0] exp_q[$];
  int          mode = 0;
  int          pix_reads = 0, xfers = 0, done_cnt = 0, errp_cnt = 0;
  int          exp_err = 0, exp_done = 0, exp_errp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source FIFO model: read data appears the cycle after queue_rd_en.
  always @(posedge clk) begin
    logic [16:0] w;
    if (fq.queue_rd_en && fifo.size() > 0) begin
      w = fifo.pop_front();
      fq.queue_data <= w;
      if (!w[16]) pix_reads++;
    end
    fq.queue_empty <= (fifo.size() == 0);
  end

  // Sink readiness: 0 = always ready, 1 = toggling, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (mode)
      1:       fq.pixel_ready = (fq.pixel_ready === 1'b1) ? 1'b0 : 1'b1;
      2:       fq.pixel_ready = 1'b0;
      default: fq.pixel_ready = 1'b1;
    endcase
  end

  // Monitor: beats, stability under backpressure, pulse counts, read throttling.
  logic        hold_prev = 1'b0;
  logic [17:0] held = '0;
  always @(negedge clk) begin
    logic [17:0] beat;
    logic        pop;
    beat = {fq.pixel_data, fq.pixel_sof, fq.pixel_sol};
    pop  = fq.pixel_valid && fq.pixel_ready;
    if (reset_n) begin
      if (hold_prev) check("stable_hold", {45'd0, fq.pixel_valid, beat}, {45'd0, 1'b1, held});
      if (fq.queue_rd_en && mode == 1)
        check("rd_outstanding", 64'((pix_reads - xfers - int'(pop)) < 2), 64'd1);
      if (pop) begin
        if (exp_q.size() == 0) check("unexpected_beat", {46'd0, beat}, 64'hDEAD);
        else                   check("beat", {46'd0, beat}, {46'd0, exp_q.pop_front()});
        xfers++;
      end
      if (frame_done) done_cnt++;
      if (err_pulse)  errp_cnt++;
    end
    hold_prev = reset_n && fq.pixel_valid && !fq.pixel_ready;
    held      = beat;
  end

  task automatic push_word(input logic [16:0] w);
    fifo.push_back(w);
  endtask

  task automatic push_pixels(input logic [15:0] base, input int n, input logic first_row,
                             input logic expect_out);
    for (int i = 0; i < n; i++) begin
      push_word({1'b0, base + 16'(i)});
      if (expect_out) exp_q.push_back({base + 16'(i), first_row && i == 0, i == 0});
    end
  endtask

  task automatic send_frame(input logic [15:0] base, input int r0, input int r1);
    push_word(MK_FRAME_START);
    push_word(MK_ROW_START);
    push_pixels(base, r0, 1'b1, 1'b1);
    push_word(MK_ROW_START);
    push_pixels(base + 16'h0100, r1, 1'b0, 1'b1);
    push_word(MK_FRAME_END);
    exp_done++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || fq.pixel_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check({name, "_drain_timeout"}, 64'd1, 64'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic end_checks(input string name);
    check({name, "_err_count"}, {48'd0, err_count}, 64'(exp_err));
    check({name, "_frame_done"}, 64'(done_cnt), 64'(exp_done));
    check({name, "_err_pulses"}, 64'(errp_cnt), 64'(exp_errp));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {29'd0, fq.pixel_valid, fq.pixel_sof, fq.pixel_sol, frame_done, err_pulse,
                 fq.queue_rd_en, fq.pixel_data, err_count}, 64'd0);
  endtask

  initial begin
    int n, cnt;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1: nominal frame at full rate, with latency and throughput of the first row.
    push_word(MK_FRAME_START);
    push_word(MK_ROW_START);
    repeat (8) @(negedge clk);
    push_pixels(16'hA000, W, 1'b1, 1'b1);
    push_word(MK_ROW_START);
    push_pixels(16'hA100, W, 1'b0, 1'b1);
    push_word(MK_FRAME_END);
    exp_done++;
    n = 0;
    while (!fq.queue_rd_en && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!fq.pixel_valid && n < 10);
    check("first_pixel_latency", 64'(n), 64'd2);
    cnt = 1;
    repeat (W - 1) begin @(negedge clk); if (fq.pixel_valid) cnt++; end
    check("row_throughput", 64'(cnt), 64'(W));
    wait_drain("t1");
    end_checks("t1");

    // T2: same frame with the sink toggling readiness every cycle.
    mode = 1;
    send_frame(16'hB000, W, W);
    wait_drain("t2");
    mode = 0;
    end_checks("t2");

    // T3: short second row; only a geometry-checking build flags it.
    send_frame(16'hC000, W, 3);
`ifdef FRAME_GEOMETRY_CHECK_EN
    exp_err++;
    exp_errp++;
`endif
    wait_drain("t3");
    end_checks("t3");

    // T4: stray pixels before frame start are dropped, one error each.
    push_pixels(16'hD0F0, 2, 1'b0, 1'b0);
    exp_err += 2;
    exp_errp += 2;
    send_frame(16'hD000, W, W);
    wait_drain("t4");
    end_checks("t4");

    // T5: unknown control word inside a row is an error and not a pixel.
    push_word(MK_FRAME_START);
    push_word(MK_ROW_START);
    push_pixels(16'hE000, 2, 1'b1, 1'b1);
    push_word(17'h10005);
    push_word(17'h0E002);
    push_word(17'h0E003);
    exp_q.push_back({16'hE002, 1'b0, 1'b0});
    exp_q.push_back({16'hE003, 1'b0, 1'b0});
    push_word(MK_ROW_START);
    push_pixels(16'hE100, W, 1'b0, 1'b1);
    push_word(MK_FRAME_END);
    exp_done++;
    exp_err++;
    exp_errp++;
    wait_drain("t5");
    end_checks("t5");

    // T6: reset mid-frame with buffered pixels, then a clean frame.
    mode = 2;
    push_word(MK_FRAME_START);
    push_word(MK_ROW_START);
    push_pixels(16'hF000, W, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("t6_buffered_before_reset", {63'd0, fq.pixel_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset_outputs");
    fifo.delete();
    exp_err = 0;
    repeat (3) @(negedge clk);
    mode = 0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(16'h5000, W, W);
    wait_drain("t6");
    end_checks("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
